// File: rtl/uart_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_pkg : shared constants for the UART transmit queue.        Rev 1.0
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_TXQ_ADDR_BITS    = 4;
  localparam int unsigned UART_TXQ_BUSY_TIMEOUT = 8;

  typedef logic [1:0] txq_state_t;

  localparam txq_state_t ST_IDLE      = 2'd0;
  localparam txq_state_t ST_WAIT_BUSY = 2'd1;
  localparam txq_state_t ST_WAIT_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_queue_mem.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_tx_queue_mem : byte array, registered write, combinational read. Rev 1.0
// -----------------------------------------------------------------------------
module uart_tx_queue_mem
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_BITS = UART_TXQ_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [7:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_tx_queue : MMIO byte FIFO drained one byte at a time into the UART core. Rev 1.0
// -----------------------------------------------------------------------------
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = UART_TXQ_ADDR_BITS,
  parameter int unsigned BUSY_TIMEOUT = UART_TXQ_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 clear,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   level,
  output logic                 overflow,
  output logic                 idle,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_busy
);

  localparam int unsigned   CNT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  txq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               do_push;
  logic               do_pop;
  logic [7:0]         rd_data;

  uart_tx_queue_mem #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q[ADDR_BITS-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ADDR_BITS-1:0]),
    .rdata_o (rd_data)
  );

  // The extra pointer MSB separates a full ring from an empty one.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                    (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);
  assign overflow = overflow_q;
  assign idle     = empty && (state_q == ST_IDLE);
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

  // A pop in the same cycle frees a slot, so a write to a full queue still lands.
  assign do_push = wr_en && !clear && (!full || do_pop);

  always_comb begin : ptr_next
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !do_push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin : ptr_reg
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin : fsm_reg
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // The timeout covers a UART core that swallows a byte with no visible busy.
  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (do_pop) begin
          state_d = ST_WAIT_BUSY;
          cnt_d   = '0;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A flush in progress suppresses the launch of a byte it is discarding.
  always_comb begin : fsm_out
    do_pop     = (state_q == ST_IDLE) && !empty && !tx_busy && !clear;
    tx_valid_d = do_pop;
    tx_data_d  = do_pop ? rd_data : tx_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_uart_tx_queue : directed + random bench with a queue-level reference model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int ADDR_BITS = 4;
  localparam int DEPTH     = 16;
  localparam int T         = 8;

  logic                 clk     = 1'b0;
  logic                 resetn  = 1'b1;
  logic                 wr_en   = 1'b0;
  logic [7:0]           wr_data = 8'h00;
  logic                 clear   = 1'b0;
  logic                 full, empty, overflow, idle, tx_valid;
  logic [ADDR_BITS:0]   level;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  always #5 clk = ~clk;

  uart_tx_queue #(.ADDR_BITS(ADDR_BITS), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .idle(idle),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART core stand-in: busy one cycle after tx_ena for busy_len cycles.
  bit uart_never = 0;
  bit uart_hold  = 0;
  int busy_len   = 500;
  int ub_cnt     = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ub_cnt  <= 0;
      tx_busy <= 1'b0;
    end else if (!uart_never && tx_valid) begin
      ub_cnt  <= busy_len - 1;
      tx_busy <= 1'b1;
    end else if (ub_cnt > 0) begin
      ub_cnt  <= ub_cnt - 1;
      tx_busy <= 1'b1;
    end else begin
      tx_busy <= uart_hold;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: byte queue plus "one launch outstanding" bookkeeping.
  byte unsigned mq[$];
  bit           m_ovf   = 0;
  bit           m_out   = 0;
  bit           m_seen  = 0;
  int           m_age   = 0;
  bit           m_valid = 0;
  logic [7:0]   m_data  = 8'h00;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_ovf = 0; m_out = 0; m_seen = 0; m_age = 0; m_valid = 0; m_data = 8'h00;
    end else begin
      bit p_pop, p_push;
      p_pop  = !m_out && (mq.size() > 0) && !tx_busy && !clear;
      p_push = wr_en && !clear && ((mq.size() < DEPTH) || p_pop);
      if (m_out) begin
        if (m_seen) begin
          if (!tx_busy) m_out = 0;
        end else if (tx_busy) begin
          m_seen = 1;
        end else begin
          m_age++;
          if (m_age >= T) m_out = 0;
        end
      end
      m_valid = p_pop;
      if (p_pop) begin
        m_data = mq.pop_front();
        m_out = 1; m_seen = 0; m_age = 0;
      end
      if (clear) begin
        mq.delete();
        m_ovf = 0;
      end else if (wr_en && !p_push) begin
        m_ovf = 1;
      end
      if (p_push) mq.push_back(wr_data);
    end
  end

  int l_cyc[$];
  int l_dat[$];

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("level",    32'(level),    32'(mq.size()));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("full",     32'(full),     32'(mq.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("idle",     32'(idle),     32'((mq.size() == 0) && !m_out));
      check("tx_valid", 32'(tx_valid), 32'(m_valid));
      check("tx_data",  32'(tx_data),  32'(m_data));
      if (tx_valid === 1'b1) begin
        l_cyc.push_back(cyc);
        l_dat.push_back(int'(tx_data));
      end
    end
  end

  function automatic int lc(input int i);
    return (i < l_cyc.size()) ? l_cyc[i] : -1;
  endfunction
  function automatic int ld(input int i);
    return (i < l_dat.size()) ? l_dat[i] : -1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (!(idle && !tx_busy) && k < max) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(idle && !tx_busy), 32'd1);
  endtask

  task automatic clear_log();
    l_cyc.delete();
    l_dat.delete();
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int push_edge;
    int k;
    #2 resetn = 1'b0;
    chk_en = 1;
    tick(2);
    resetn = 1'b1;

    check("rst_level",    32'(level),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_idle",     32'(idle),     32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);

    // Single byte, launch latency.
    tick(1);
    clear_log();
    push_edge = cyc + 1;
    push(8'h41);
    wait_idle("t1_idle", 700);
    check("t1_count",   32'(l_cyc.size()), 32'd1);
    check("t1_latency", 32'(lc(0)),        32'(push_edge + 1));
    check("t1_data",    32'(ld(0)),        32'h41);

    // Fill to full, overflow, ordered drain.
    uart_hold = 1; tick(2);
    clear_log();
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t2_full",  32'(full),  32'd1);
    check("t2_level", 32'(level), 32'd16);
    push(8'hFF);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_level_ff", 32'(level),    32'd16);
    uart_hold = 0;
    wait_idle("t2_idle", 16 * 520);
    check("t2_count", 32'(l_cyc.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t2_order", 32'(ld(i)), 32'(i));
      if (i > 0) check("t2_spacing_ge500", 32'((lc(i) - lc(i-1)) >= 500), 32'd1);
    end

    // Write into a full queue on the pop cycle.
    clear = 1'b1; tick(1); clear = 1'b0;
    check("t3_clear_ovf", 32'(overflow), 32'd0);
    busy_len = 20;
    uart_hold = 1; tick(2);
    clear_log();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    check("t3_full", 32'(full), 32'd1);
    uart_hold = 0;
    k = 0;
    do begin tick(1); k++; end while (tx_busy && k < 10);
    check("t3_pop_window", 32'(tx_busy), 32'd0);
    wr_en = 1'b1; wr_data = 8'h55; tick(1); wr_en = 1'b0;
    check("t3_level",    32'(level),    32'd16);
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_launch",   32'(tx_valid), 32'd1);
    wait_idle("t3_idle", 17 * 40);
    check("t3_count", 32'(l_cyc.size()), 32'd17);
    check("t3_last",  32'(ld(16)),       32'h55);

    // UART never raises busy: timeout pacing.
    uart_never = 1;
    clear_log();
    push(8'h01); push(8'h02); push(8'h03);
    wait_idle("t4_idle", 100);
    check("t4_count", 32'(l_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("t4_data", 32'(ld(i)), 32'(i + 1));
    check("t4_gap1", 32'(lc(1) - lc(0)), 32'(T + 1));
    check("t4_gap2", 32'(lc(2) - lc(1)), 32'(T + 1));

    // Clear with one byte in flight and five queued.
    uart_never = 0; busy_len = 500;
    clear_log();
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    check("t5_pre_level", 32'(level),   32'd5);
    check("t5_pre_busy",  32'(tx_busy), 32'd1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("t5_level",    32'(level),    32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    wait_idle("t5_idle", 700);
    tick(50);
    check("t5_count", 32'(l_cyc.size()), 32'd1);
    check("t5_data",  32'(ld(0)),        32'h60);

    // Asynchronous reset during WAIT_DONE.
    clear_log();
    for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
    tick(3);
    check("t6_pre_level", 32'(level),   32'd4);
    check("t6_pre_busy",  32'(tx_busy), 32'd1);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("t6_level",    32'(level),    32'd0);
    check("t6_empty",    32'(empty),    32'd1);
    check("t6_full",     32'(full),     32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_idle",     32'(idle),     32'd1);
    check("t6_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_tx_data",  32'(tx_data),  32'h00);
    tick(2);
    resetn = 1'b1;
    clear_log();
    tick(40);
    check("t6_no_launch", 32'(l_cyc.size()), 32'd0);

    // Randomised traffic against the model.
    for (int seg = 0; seg < 6; seg++) begin
      uart_never = ($urandom_range(0, 3) == 0);
      busy_len   = $urandom_range(1, 12);
      for (int c = 0; c < 500; c++) begin
        wr_en     = ($urandom_range(0, 99) < 60);
        wr_data   = 8'($urandom);
        clear     = ($urandom_range(0, 99) < 2);
        uart_hold = ($urandom_range(0, 99) < 10);
        tick(1);
      end
    end
    wr_en = 1'b0; clear = 1'b0; uart_hold = 0; uart_never = 1;
    wait_idle("rand_drain", 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side byte queue between the MMIO peripheral block and the UART core. MMIO writes bytes into a small FIFO at CPU speed. A drain state machine pops bytes one at a time and presents them to the UART core's `tx_ena`/`tx_data` inputs, pacing itself on `tx_busy`. Firmware therefore never stalls on a per-byte busy poll.

## Interface
- `ADDR_BITS`, default 4: FIFO depth is 2^ADDR_BITS entries (16).
- `BUSY_TIMEOUT`, default 8: cycles to wait for `tx_busy` to rise after a launch before returning to IDLE.
- `clk`, input, 1: system clock (50 MHz).
- `resetn`, input, 1: reset, asynchronous and active-low.
- `wr_en`, input, 1: push `wr_data` this cycle.
- `wr_data`, input, 8: byte to enqueue.
- `clear`, input, 1: synchronous flush of queued bytes; also clears `overflow`.
- `full`, output, 1: FIFO holds 2^ADDR_BITS entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `level`, output, ADDR_BITS+1: current occupancy.
- `overflow`, output, 1: sticky flag, set when a write is dropped.
- `idle`, output, 1: FIFO empty and FSM in IDLE (transmit queue fully drained to the UART core).
- `tx_data`, output, 8: byte to the UART core.
- `tx_valid`, output, 1: one-cycle launch pulse to the UART core's `tx_ena`.
- `tx_busy`, input, 1: UART core busy.

## Operation
- Storage: circular array, with `wr_ptr` and `rd_ptr` each ADDR_BITS+1 bits wide.
  - The extra MSB distinguishes full from empty.
  - `level = wr_ptr - rd_ptr`, modulo 2^(ADDR_BITS+1).
  - Pointers wrap naturally with no special case at the top of the array.
- Push: accepted when `wr_en` is high and `full` is low.
  - `wr_en` while `full`: byte dropped, `overflow` set, pointers unchanged.
- Pop: performed only by the FSM.
- Simultaneous push and pop: both occur, `level` unchanged. This holds when full; the push is accepted because the pop frees an entry in the same cycle.
- FSM states:
  - IDLE: if `!empty && !tx_busy`, pop `mem[rd_ptr]` into the `tx_data` register, pulse `tx_valid` for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: count cycles.
    - `tx_busy` high: go to WAIT_DONE.
    - Count reaches BUSY_TIMEOUT: go to IDLE. This covers a UART core that absorbed the byte without a visible busy pulse.
  - WAIT_DONE: `tx_busy` low: go to IDLE.
- `tx_data` holds its value from launch until the next launch.
- `clear` behaviour:
  - Zeroes both pointers and `overflow`.
  - Does not abort an in-flight byte; the FSM finishes its WAIT states normally.
  - `clear` and `wr_en` in the same cycle: `clear` wins and the write is dropped without setting `overflow`.
- Reset values:
  - Pointers 0, `empty` 1, `full` 0, `level` 0, `overflow` 0, `idle` 1.
  - `tx_valid` 0, `tx_data` 8'h00, FSM in IDLE.
- Reset asserted mid-transmission: everything returns to the reset values immediately. No further `tx_valid` is issued; the UART core is reset by the same `resetn`.

## Timing
- All outputs are registered.
- Write latency: push in cycle N makes `empty`, `full` and `level` reflect it in N+1.
- Launch latency: push into an empty queue in cycle N, with `tx_busy` low, gives `tx_valid` high in cycle N+2.
- `tx_valid` is never high on two consecutive cycles.
- Back-to-back bytes: the next `tx_valid` comes no earlier than 1 cycle after `tx_busy` falls.
- Throughput is bounded by the UART: at 1 Mbaud, 8N1, one byte every 500 clk cycles.
- `tx_valid` is never asserted while `tx_busy` is high.

## Structure
- Shared package `uart_pkg`, holding:
  - FSM state encodings: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2.
  - Default depth constant.
  - BUSY_TIMEOUT default.
- Sub-module `uart_tx_queue_mem`: simple dual-port array with a registered write and a combinational read at `rd_ptr`.
- Pointer, flag and FSM logic stays in the top module.

## Test plan
- Reset then single push of 8'h41 in cycle N, with a UART model that raises `tx_busy` 1 cycle after `tx_ena` for 500 cycles:
  - `tx_valid` at N+2 with `tx_data`=8'h41.
  - `idle` high after `tx_busy` falls.
- Push 16 bytes 8'h00..8'h0F back-to-back, then push a 17th byte 8'hFF:
  - `full`=1 and `level`=16.
  - `overflow`=1, and 8'hFF never appears on `tx_data`.
  - 16 launches arrive in order 8'h00..8'h0F, each spaced ≥500 cycles.
- Queue full; write in the same cycle as the FSM pop: write accepted, `level` stays 16, `overflow` stays 0.
- UART model that never raises `tx_busy`, with 3 bytes queued: each launch is separated by BUSY_TIMEOUT+1 cycles, and all 3 bytes are delivered.
- 5 bytes queued, one in flight, assert `clear`:
  - `level`=0 next cycle and `overflow`=0.
  - The in-flight byte completes and no further `tx_valid` appears.
- Assert `resetn` low asynchronously (mid-clock) during WAIT_DONE with 4 bytes queued:
  - All outputs reach their reset values immediately.
  - No `tx_valid` appears after release until a new push.
